// File: rtl/obi_arbiter.sv
// Two-manager OBI arbiter with in-order response routing; OBI_ARB_ROUND_ROBIN_EN selects round-robin ties.
// Zero-cycle grant and response paths; issue stalls while the ID FIFO is full or s_gnt is low.
module obi_arbiter #(
   parameter int WIDTH           = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m0_req,
   output logic             m0_gnt,
   input  logic [WIDTH-1:0] m0_addr,
   input  logic             m0_we,
   input  logic [3:0]       m0_be,
   input  logic [WIDTH-1:0] m0_wdata,
   output logic             m0_rvalid,
   output logic [WIDTH-1:0] m0_rdata,
   input  logic             m1_req,
   output logic             m1_gnt,
   input  logic [WIDTH-1:0] m1_addr,
   input  logic             m1_we,
   input  logic [3:0]       m1_be,
   input  logic [WIDTH-1:0] m1_wdata,
   output logic             m1_rvalid,
   output logic [WIDTH-1:0] m1_rdata,
   output logic             s_req,
   input  logic             s_gnt,
   output logic [WIDTH-1:0] s_addr,
   output logic             s_we,
   output logic [3:0]       s_be,
   output logic [WIDTH-1:0] s_wdata,
   input  logic             s_rvalid,
   input  logic [WIDTH-1:0] s_rdata
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [CW-1:0]              r_cnt;
   logic [PW-1:0]              r_rd_ptr;
   logic [PW-1:0]              r_wr_ptr;
   logic [MAX_OUTSTANDING-1:0] r_ids;
   logic                       r_lock;
   logic                       r_locked_id;

   logic w_sel;
   logic w_sel_req;
   logic w_full;
   logic w_hs;
   logic w_pop;
   logic w_head;
   logic w_tie_sel;

   // A depth-1 FIFO has a single slot, so its pointers never move.
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      if (MAX_OUTSTANDING == 1) return '0;
      return p + 1'b1;
   endfunction

`ifdef OBI_ARB_ROUND_ROBIN_EN
   logic r_rr;

   assign w_tie_sel = r_rr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_rr <= 1'b0;
      else if (w_hs) r_rr <= ~w_sel;
   end
`else
   assign w_tie_sel = 1'b1;
`endif

   always_comb begin
      w_sel = 1'b0;
      if (r_lock)               w_sel = r_locked_id;
      else if (m0_req && m1_req) w_sel = w_tie_sel;
      else                      w_sel = m1_req;
   end

   assign w_sel_req = w_sel ? m1_req : m0_req;
   assign w_full    = (r_cnt == CW'(MAX_OUTSTANDING));
   assign w_hs      = s_req & s_gnt;
   assign w_pop     = s_rvalid & (r_cnt != '0);
   assign w_head    = r_ids[r_rd_ptr];

   assign s_req   = w_sel_req & ~w_full;
   assign s_addr  = w_sel ? m1_addr  : m0_addr;
   assign s_we    = w_sel ? m1_we    : m0_we;
   assign s_be    = w_sel ? m1_be    : m0_be;
   assign s_wdata = w_sel ? m1_wdata : m0_wdata;

   assign m0_gnt    = w_hs & ~w_sel;
   assign m1_gnt    = w_hs &  w_sel;
   assign m0_rvalid = w_pop & ~w_head;
   assign m1_rvalid = w_pop &  w_head;
   assign m0_rdata  = s_rdata;
   assign m1_rdata  = s_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_ids       <= '0;
         r_lock      <= 1'b0;
         r_locked_id <= 1'b0;
      end else begin
         if (w_hs) begin
            r_ids[r_wr_ptr] <= w_sel;
            r_wr_ptr        <= f_inc(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
         if (w_hs && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (!w_hs && w_pop) r_cnt <= r_cnt - CW'(1);
         // An issued address phase must stay put until the memory accepts it.
         if (w_hs) begin
            r_lock <= 1'b0;
         end else if (s_req) begin
            r_lock      <= 1'b1;
            r_locked_id <= w_sel;
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && s_rvalid)
         assert (r_cnt != '0)
         else $warning("obi_arbiter: s_rvalid with no outstanding transaction, dropped");
   end
`endif

endmodule

// File: tb/tb_obi_arbiter.sv
// Randomised and directed bench for obi_arbiter against a queue-based model of issue order and routing.
module tb_obi_arbiter;
   localparam int W   = 32;
   localparam int MAX = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
   logic [W-1:0]  m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
   logic [3:0]    m0_be = 0, m1_be = 0;
   logic          s_gnt = 0, s_rvalid = 0;
   logic [W-1:0]  s_rdata = 0;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_req, s_we;
   logic [W-1:0]  m0_rdata, m1_rdata, s_addr, s_wdata;
   logic [3:0]    s_be;

   obi_arbiter #(.WIDTH(W), .MAX_OUTSTANDING(MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
      .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
      .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .s_req(s_req), .s_gnt(s_gnt), .s_addr(s_addr), .s_we(s_we), .s_be(s_be),
      .s_wdata(s_wdata), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: outstanding IDs in issue order, the manager whose address phase is pending, tie preference.
   bit mq[$];
   bit pend_vld = 0, pend_id = 0, m_rr = 0;

   always @(negedge clk) begin
      bit sel, sreq, pop, head;
      if (!rst_n) begin
         mq.delete();
         pend_vld = 0;
         m_rr     = 0;
      end else if (chk_en) begin
         if (pend_vld)              sel = pend_id;
`ifdef OBI_ARB_ROUND_ROBIN_EN
         else if (m0_req && m1_req) sel = m_rr;
`else
         else if (m0_req && m1_req) sel = 1'b1;
`endif
         else                       sel = m1_req;
         sreq = (sel ? m1_req : m0_req) && (mq.size() < MAX);
         chk("s_req", s_req, sreq);
         chk("m0_gnt", m0_gnt, sreq && s_gnt && !sel);
         chk("m1_gnt", m1_gnt, sreq && s_gnt && sel);
         if (sreq) begin
            chk("s_addr",  s_addr,  sel ? m1_addr  : m0_addr);
            chk("s_we",    s_we,    sel ? m1_we    : m0_we);
            chk("s_be",    s_be,    sel ? m1_be    : m0_be);
            chk("s_wdata", s_wdata, sel ? m1_wdata : m0_wdata);
         end
         pop  = s_rvalid && (mq.size() > 0);
         head = pop ? mq[0] : 1'b0;
         chk("m0_rvalid", m0_rvalid, pop && !head);
         chk("m1_rvalid", m1_rvalid, pop && head);
         if (pop) begin
            chk("m0_rdata", m0_rdata, s_rdata);
            chk("m1_rdata", m1_rdata, s_rdata);
            void'(mq.pop_front());
         end
         if (sreq && s_gnt) begin
            mq.push_back(sel);
            pend_vld = 0;
            m_rr     = !sel;
         end else if (sreq) begin
            pend_vld = 1;
            pend_id  = sel;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         s_rvalid = 1; s_rdata = $urandom;
         neg();
         step();
      end
      s_rvalid = 0;
   endtask

   bit g0, g1;
   bit exp_seq[4];
   bit got_seq[4];

   initial begin
      // Reset state
      neg();
      chk("rst_s_req", s_req, 0);
      chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      step();
      rst_n = 1; chk_en = 1;
      step();

      // Single m0 read, granted immediately, response two cycles later
      m0_req = 1; m0_addr = 32'h40; m0_be = 4'hF; s_gnt = 1;
      neg(); chk("t1_m0_gnt", m0_gnt, 1);
      step(); m0_req = 0; s_gnt = 0;
      neg(); chk("t1_gnt_pulse", m0_gnt, 0);
      step(); s_rvalid = 1; s_rdata = 32'hDEADBEEF;
      neg();
      chk("t1_m0_rvalid", m0_rvalid, 1);
      chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
      chk("t1_m1_rvalid", m1_rvalid, 0);
      step(); s_rvalid = 0;

      // Both request: data port first, responses routed in issue order
      m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200; s_gnt = 1;
      neg(); chk("t2_addr1", s_addr, 32'h200); chk("t2_m1_gnt", m1_gnt, 1);
      step(); m1_req = 0;
      neg(); chk("t2_addr2", s_addr, 32'h100); chk("t2_m0_gnt", m0_gnt, 1);
      step(); m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hAAAA0001;
      neg(); chk("t2_rsp_a", {m1_rvalid, m0_rvalid}, 2'b10);
      step(); s_rdata = 32'hBBBB0002;
      neg(); chk("t2_rsp_b", {m1_rvalid, m0_rvalid}, 2'b01);
      step(); s_rvalid = 0;

      // Lock: m0 issued while s_gnt low must not be displaced by m1
      m0_req = 1; m0_addr = 32'h100;
      neg(); chk("t3_s_req", s_req, 1); chk("t3_addr0", s_addr, 32'h100);
      step(); m1_req = 1; m1_addr = 32'h200;
      neg(); chk("t3_addr1", s_addr, 32'h100);
      step();
      neg(); chk("t3_addr2", s_addr, 32'h100);
      step(); s_gnt = 1;
      neg(); chk("t3_gnt", {m1_gnt, m0_gnt}, 2'b01);
      step(); m0_req = 0;
      neg(); chk("t3_m1_gnt", m1_gnt, 1); chk("t3_addr_m1", s_addr, 32'h200);
      step(); m1_req = 0; s_gnt = 0;
      drain(2);

      // Full FIFO blocks the third issue, even in the cycle a response arrives
      m0_req = 1; m0_addr = 32'h10; s_gnt = 1;
      neg();
      step(); m0_addr = 32'h14;
      neg();
      step(); m0_addr = 32'h18;
      neg(); chk("t4_full_sreq", s_req, 0); chk("t4_full_gnt", m0_gnt, 0);
      step(); s_rvalid = 1; s_rdata = 32'h11;
      neg(); chk("t4_full_rv_sreq", s_req, 0); chk("t4_rvalid", m0_rvalid, 1);
      step(); s_rvalid = 0;
      neg(); chk("t4_resume_gnt", m0_gnt, 1); chk("t4_resume_addr", s_addr, 32'h18);
      step(); m0_req = 0; s_gnt = 0;
      drain(2);

      // Reset with two outstanding; late responses are dropped
      m1_req = 1; m1_addr = 32'h300; s_gnt = 1;
      neg();
      step(); m1_addr = 32'h304;
      neg();
      step(); m1_req = 0; s_gnt = 0; rst_n = 0;
      neg();
      step(); rst_n = 1; s_rvalid = 1; s_rdata = 32'h5;
      neg(); chk("t5_late_rv0", {m0_rvalid, m1_rvalid}, 0);
      step();
      neg(); chk("t5_late_rv1", {m0_rvalid, m1_rvalid}, 0);
      step(); s_rvalid = 0; m0_req = 1; m0_addr = 32'h500; s_gnt = 1;
      neg(); chk("t5_post_gnt", m0_gnt, 1);
      step(); m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h77;
      neg(); chk("t5_post_rv", {m1_rvalid, m0_rvalid}, 2'b01);
      step(); s_rvalid = 0;

      // Continuous contention right after reset
      rst_n = 0;
      neg();
      step(); rst_n = 1;
`ifdef OBI_ARB_ROUND_ROBIN_EN
      exp_seq = '{0, 1, 0, 1};
`else
      exp_seq = '{1, 1, 1, 1};
`endif
      m0_req = 1; m1_req = 1; s_gnt = 1;
      for (int i = 0; i < 4; i++) begin
         m0_addr = 32'h1000 + i * 4; m1_addr = 32'h2000 + i * 4;
         s_rvalid = (i > 0); s_rdata = $urandom;
         neg();
         got_seq[i] = m1_gnt;
         chk("t6_one_gnt", m0_gnt ^ m1_gnt, 1);
         chk("t6_gnt_order", got_seq[i], exp_seq[i]);
         step();
      end
      m0_req = 0; m1_req = 0; s_gnt = 0;
      drain(1);

      // Randomised traffic honouring OBI: requests held with stable payload until granted
      for (int c = 0; c < 4000; c++) begin
         neg();
         g0 = m0_gnt; g1 = m1_gnt;
         step();
         if (m0_req && g0) m0_req = 0;
         if (m1_req && g1) m1_req = 0;
         if (!m0_req && ($urandom % 3 == 0)) begin
            m0_req = 1; m0_addr = $urandom; m0_be = 4'($urandom); m0_wdata = $urandom;
         end
         if (!m1_req && ($urandom % 3 == 0)) begin
            m1_req = 1; m1_addr = $urandom; m1_be = 4'($urandom); m1_wdata = $urandom;
            m1_we = 1'($urandom);
         end
         s_gnt    = 1'($urandom);
         s_rdata  = $urandom;
         s_rvalid = (mq.size() > 0) && ($urandom % 2 == 0);
      end
      m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0;
      neg();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/obi_arbiter.md
Name: obi_arbiter

Overview:
- Shares one OBI subordinate port (the unified memory) between two OBI managers: instruction fetch (m0) and load/store unit (m1).
- Sits between the core's fetch and LSU OBI controllers and the memory.
- Arbitrates the address phase and keeps the selection stable until grant.
- Records each granted requester in an in-order ID FIFO, then routes each response (rvalid/rdata) back to its originator.

Parameters:
- WIDTH, 32, width of addr/wdata/rdata.
- MAX_OUTSTANDING, 2, depth of the outstanding-transaction ID FIFO (power of 2, ≥1).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- m0_req / m1_req  input  1  manager address-phase request
- m0_gnt / m1_gnt  output  1  grant to manager
- m0_addr / m1_addr  input  WIDTH  byte address
- m0_we / m1_we  input  1  write enable (m0_we tied 0 by integrator)
- m0_be / m1_be  input  4  byte enables
- m0_wdata / m1_wdata  input  WIDTH  write data
- m0_rvalid / m1_rvalid  output  1  response valid to manager
- m0_rdata / m1_rdata  output  WIDTH  response data (both driven from s_rdata)
- s_req  output  1  request to memory
- s_gnt  input  1  memory grant
- s_addr  output  WIDTH  muxed address
- s_we  output  1  muxed write enable
- s_be  output  4  muxed byte enables
- s_wdata  output  WIDTH  muxed write data
- s_rvalid  input  1  memory response valid
- s_rdata  input  WIDTH  memory response data

Behaviour:
- Reset (rst_n low, async): ID FIFO empty (count=0, rd/wr ptr=0), lock=0, locked_id=0, rr pointer=0.
  - Outputs are combinational from state. With FIFO empty and no requests: s_req=0, m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0.
- Arbitration (no lock): if both request, m1 (data) wins (fixed priority); otherwise the sole requester wins.
- Lock:
  - If s_req=1 and s_gnt=0 at a clock edge, set lock=1 and store locked_id.
  - Selection stays at locked_id until s_gnt; the OBI address phase must not change once issued.
  - The locked manager is never dropped, even if the other manager raises req.
- Address phase:
  - s_req = selected m*_req AND (count < MAX_OUTSTANDING).
  - s_addr/we/be/wdata come from the selected manager.
  - m*_gnt = s_gnt AND s_req AND (selected == *). The non-selected gnt is 0.
- Handshake: a transfer occurs on s_req & s_gnt.
  - Push selected ID into the FIFO; clear lock.
  - Zero-latency grant: req and gnt in the same cycle costs 1 cycle.
- Response phase:
  - On s_rvalid, pop the FIFO head. The head ID selects which m*_rvalid pulses (same cycle, combinational).
  - Responses return in issue order; the FIFO enforces it.
- Push and pop in the same cycle: count unchanged, both pointers advance (mod MAX_OUTSTANDING).
- FIFO full (count == MAX_OUTSTANDING): s_req=0, no grants, even if s_rvalid arrives that cycle. Issue resumes next cycle.
- s_rvalid with FIFO empty: protocol violation. No m*_rvalid, no state change; simulation assertion fires.
- Reset mid-transaction: FIFO cleared. Late responses from the memory for pre-reset requests hit the empty-FIFO rule and are dropped.
- Pointer wrap: pointers are log2(MAX_OUTSTANDING) bits and wrap naturally. For MAX_OUTSTANDING=1 there is a single entry with no pointer.

Optional Feature:
- Macro: OBI_ARB_ROUND_ROBIN_EN.
- Defined: unlocked ties resolve round-robin.
  - 1-bit rr pointer names the preferred manager.
  - After every handshake, the pointer is set to the opposite of the ID just granted.
  - Reset value 0 (prefer m0).
- Undefined: fixed priority, m1 over m0; no rr register is synthesized.
- Lock, FIFO and response routing are identical in both builds.

Test Plan:
- Single read m0, s_gnt same cycle, s_rvalid 2 cycles later with rdata=0xDEADBEEF:
  - m0_gnt pulses 1 cycle, then m0_rvalid=1 with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Both req, m0_addr=0x100, m1_addr=0x200 (fixed priority):
  - s_addr=0x200 and m1_gnt first, then 0x100 and m0_gnt.
  - Responses A then B route to m1 then m0.
- Lock: m0 alone requests, s_gnt held 0 for 3 cycles, m1_req rises at cycle 1:
  - s_addr stays 0x100 until gnt; m0_gnt fires; then m1 is served.
- Full FIFO (MAX_OUTSTANDING=2): two granted reads with no rvalid, third request:
  - s_req=0. On the first s_rvalid, the third request is granted the following cycle.
- Reset asserted with 2 outstanding, then released; memory returns s_rvalid:
  - no m0/m1_rvalid; count remains 0.
- OBI_ARB_ROUND_ROBIN_EN defined, both req continuously, s_gnt=1:
  - grants alternate m0, m1, m0, m1 starting with m0 after reset.
